// File: rtl/misc_v_pkg.sv
// misc_v_pkg: shared widths, memory-stage state type and helpers for the MISC-V core
package misc_v_pkg;
    localparam int XLEN = 16;
    localparam int RADDR_W = 3;
    typedef enum logic [1:0] {IDLE, BUSY, FAULT} mem_state_t;
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return &v ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: Execute, data-memory and Writeback signals around the memory stage
interface memory_stage_if;
    import misc_v_pkg::*;
    logic ex_valid;
    logic ex_ready;
    logic [XLEN-1:0] ex_alu_result;
    logic [XLEN-1:0] ex_store_data;
    logic [RADDR_W-1:0] ex_rd;
    logic ex_reg_write;
    logic ex_mem_read;
    logic ex_mem_write;
    logic dmem_req;
    logic dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic dmem_ack;
    logic wb_valid;
    logic wb_reg_write;
    logic [RADDR_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    modport slave(
        input ex_valid, ex_alu_result, ex_store_data, ex_rd, ex_reg_write, ex_mem_read,
              ex_mem_write, dmem_rdata, dmem_ack,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_reg_write,
               wb_rd, wb_data
    );
    modport master(
        output ex_valid, ex_alu_result, ex_store_data, ex_rd, ex_reg_write, ex_mem_read,
               ex_mem_write, dmem_rdata, dmem_ack,
        input ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_reg_write,
              wb_rd, wb_data
    );
endinterface

// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl: IDLE/BUSY/FAULT access sequencer with hung-memory timeout and dmem drive
module dmem_req_ctrl
    import misc_v_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            we,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            ack,
    output logic            req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic            done,
    output logic            idle,
    output logic            fault
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    mem_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
        end
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                state_nx = start ? BUSY : IDLE;
            end
            BUSY: begin
                cnt_nx = ack ? cnt : cnt + 1'b1;
                state_nx = ack ? IDLE : (cnt_nx == LIMIT ? FAULT : BUSY);
            end
            default: state_nx = FAULT;
        endcase
    end
    // req is a pure decode of the state flop, so async reset drops it at once
    always_comb begin
        req = state == BUSY;
        done = req & ack;
        idle = state == IDLE;
        fault = state == FAULT;
        dmem_we = req & we;
        dmem_addr = addr;
        dmem_wdata = wdata;
    end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: data-memory access stage between Execute and Writeback, with stall accounting
module memory_stage
    import misc_v_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          reset,
    memory_stage_if.slave bus,
    output logic          mem_fault,
    output logic [15:0]   stall_count
);
    logic mem_op, accept, done, idle, we_q, rw_q;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [RADDR_W-1:0] rd_q;
    assign mem_op = bus.ex_mem_read | bus.ex_mem_write;
    assign bus.ex_ready = idle & ~reset;
    assign accept = bus.ex_valid & bus.ex_ready;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            rd_q <= '0;
            rw_q <= 1'b0;
        end else if (accept & mem_op) begin
            we_q <= bus.ex_mem_write;
            addr_q <= bus.ex_alu_result;
            wdata_q <= bus.ex_store_data;
            rd_q <= bus.ex_rd;
            rw_q <= bus.ex_reg_write;
        end
    // accept and done are exclusive: one needs IDLE, the other BUSY
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bus.wb_valid <= 1'b0;
            bus.wb_reg_write <= 1'b0;
            bus.wb_rd <= '0;
            bus.wb_data <= '0;
            stall_count <= '0;
        end else begin
            bus.wb_valid <= (accept & ~mem_op) | done;
            if (accept & ~mem_op) begin
                bus.wb_rd <= bus.ex_rd;
                bus.wb_reg_write <= bus.ex_reg_write & |bus.ex_rd;
                bus.wb_data <= bus.ex_alu_result;
            end else if (done) begin
                bus.wb_rd <= rd_q;
                bus.wb_reg_write <= rw_q & ~we_q & |rd_q;
                bus.wb_data <= we_q ? addr_q : bus.dmem_rdata;
            end
            stall_count <= bus.ex_ready ? stall_count : sat_inc16(stall_count);
        end
    dmem_req_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ctrl (
        .clk(clk),
        .reset(reset),
        .start(accept & mem_op),
        .we(we_q),
        .addr(addr_q),
        .wdata(wdata_q),
        .ack(bus.dmem_ack),
        .req(bus.dmem_req),
        .dmem_we(bus.dmem_we),
        .dmem_addr(bus.dmem_addr),
        .dmem_wdata(bus.dmem_wdata),
        .done(done),
        .idle(idle),
        .fault(mem_fault)
    );
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed vectors with a writeback scoreboard for memory_stage
module tb_memory_stage;
    typedef struct {
        logic rw;
        logic [2:0] rd;
        logic [15:0] data;
    } wb_t;
    logic clk, reset, mem_fault;
    logic [15:0] stall_count;
    wb_t exp_q[$];
    int n_chk = 0;
    int n_pass = 0;
    memory_stage_if bus();
    memory_stage #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .mem_fault(mem_fault),
        .stall_count(stall_count)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                         input logic [2:0] rd, input logic rw, input logic mr, input logic mw);
        bus.ex_valid = v;
        bus.ex_alu_result = alu;
        bus.ex_store_data = sd;
        bus.ex_rd = rd;
        bus.ex_reg_write = rw;
        bus.ex_mem_read = mr;
        bus.ex_mem_write = mw;
    endtask
    task automatic ack(input logic a, input logic [15:0] d);
        bus.dmem_ack = a;
        bus.dmem_rdata = d;
    endtask
    always @(negedge clk)
        if (bus.wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_wb: got wb_valid rd=%0d data=%h, required no writeback",
                         bus.wb_rd, bus.wb_data);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_data", 32'(bus.wb_data), 32'(e.data));
                check("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
                check("wb_reg_write", 32'(bus.wb_reg_write), 32'(e.rw));
            end
        end
    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        ack(0, 0);
        #12;
        check("rst_ex_ready", 32'(bus.ex_ready), 0);
        check("rst_dmem_req", 32'(bus.dmem_req), 0);
        check("rst_wb_valid", 32'(bus.wb_valid), 0);
        check("rst_mem_fault", 32'(mem_fault), 0);
        check("rst_stall", 32'(stall_count), 0);
        #1 reset = 1'b0;
        #1 check("ready_after_rst", 32'(bus.ex_ready), 1);
        // ALU op retires one cycle later
        drive(1, 16'h1234, 0, 2, 1, 0, 0);
        exp_q.push_back('{1'b1, 3'd2, 16'h1234});
        cyc;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("alu_ready", 32'(bus.ex_ready), 1);
        cyc;
        check("alu_stall", 32'(stall_count), 0);
        // load, ack three cycles after req
        drive(1, 16'h0040, 0, 3, 1, 1, 0);
        exp_q.push_back('{1'b1, 3'd3, 16'hBEEF});
        cyc;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("ld_req", 32'(bus.dmem_req), 1);
        check("ld_we", 32'(bus.dmem_we), 0);
        check("ld_addr", 32'(bus.dmem_addr), 32'h0040);
        for (int i = 0; i < 3; i++) begin
            check("ld_ready_low", 32'(bus.ex_ready), 0);
            cyc;
        end
        ack(1, 16'hBEEF);
        check("ld_req_held", 32'(bus.dmem_req), 1);
        check("ld_addr_held", 32'(bus.dmem_addr), 32'h0040);
        cyc;
        ack(0, 0);
        check("ld_req_drop", 32'(bus.dmem_req), 0);
        check("ld_ready_back", 32'(bus.ex_ready), 1);
        check("ld_stall", 32'(stall_count), 4);
        // store with zero-wait ack
        drive(1, 16'h0010, 16'h00AA, 5, 1, 0, 1);
        exp_q.push_back('{1'b0, 3'd5, 16'h0010});
        cyc;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("st_we", 32'(bus.dmem_we), 1);
        check("st_addr", 32'(bus.dmem_addr), 32'h0010);
        check("st_wdata", 32'(bus.dmem_wdata), 32'h00AA);
        ack(1, 16'h7777);
        cyc;
        ack(0, 0);
        check("st_we_drop", 32'(bus.dmem_we), 0);
        check("st_req_drop", 32'(bus.dmem_req), 0);
        check("st_stall", 32'(stall_count), 5);
        // read and write both set behaves as a store
        drive(1, 16'h0030, 16'h1111, 4, 1, 1, 1);
        exp_q.push_back('{1'b0, 3'd4, 16'h0030});
        cyc;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rw_both_we", 32'(bus.dmem_we), 1);
        ack(1, 16'h2222);
        cyc;
        ack(0, 0);
        // load to r0 still pulses wb_valid but never writes
        drive(1, 16'h0022, 0, 0, 1, 1, 0);
        exp_q.push_back('{1'b0, 3'd0, 16'h5A5A});
        cyc;
        drive(0, 0, 0, 0, 0, 0, 0);
        ack(1, 16'h5A5A);
        cyc;
        ack(0, 0);
        check("r0_stall", 32'(stall_count), 7);
        ack(1, 16'hFFFF);
        cyc;
        ack(0, 0);
        check("spur_req", 32'(bus.dmem_req), 0);
        check("spur_ready", 32'(bus.ex_ready), 1);
        check("spur_stall", 32'(stall_count), 7);
        // reset in the middle of an access discards it
        drive(1, 16'h0050, 0, 1, 1, 1, 0);
        cyc;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("mid_req", 32'(bus.dmem_req), 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_req", 32'(bus.dmem_req), 0);
        check("mid_rst_fault", 32'(mem_fault), 0);
        check("mid_rst_stall", 32'(stall_count), 0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        drive(1, 16'h0BAD, 0, 7, 1, 0, 0);
        exp_q.push_back('{1'b1, 3'd7, 16'h0BAD});
        cyc;
        // hung load times out after 8 BUSY cycles
        drive(1, 16'h0060, 0, 2, 1, 1, 0);
        cyc;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc;
        check("to_not_yet", 32'(mem_fault), 0);
        check("to_req_still", 32'(bus.dmem_req), 1);
        cyc;
        check("to_fault", 32'(mem_fault), 1);
        check("to_req_drop", 32'(bus.dmem_req), 0);
        check("to_ready", 32'(bus.ex_ready), 0);
        check("to_stall", 32'(stall_count), 8);
        ack(1, 16'h3333);
        drive(1, 16'h4444, 0, 6, 1, 0, 0);
        cyc;
        ack(0, 0);
        cyc;
        cyc;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("fault_sticky", 32'(mem_fault), 1);
        check("fault_ready", 32'(bus.ex_ready), 0);
        check("fault_stall", 32'(stall_count), 11);
        cyc;
        check("wb_queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
